// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// MDU op codes and the default multiply/divide latency.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MDU_NONE  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;

  localparam int MDU_CYCLES_DEF = 32;

  // Code 11 is reserved and behaves like "no MDU op".
  function automatic logic is_mdu_op(input logic [1:0] op);
    return (op == MDU_MULTU) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard.sv
// Load-use hazard comparator: a load in EX whose destination feeds the
// instruction currently in ID.
module pipe_hazard_detect (
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  output logic       load_use
);

  // $zero never carries a dependency.
  assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: arbitrates MDU occupancy, load-use and
// taken-branch hazards into plain enables and bubble controls.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ex_mdu_op,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       branch_taken,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       mdu_start,
  output logic       mdu_busy,
  output logic       hilo_we
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             mdu_go;

  pipe_hazard_detect u_hazard (
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .load_use      (load_use)
  );

  assign mdu_go = is_mdu_op(ex_mdu_op);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mdu_go) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MDU_CYCLES - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output priority mux: MDU > load-use > branch
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_start   = 1'b0;
    mdu_busy    = 1'b0;
    hilo_we     = 1'b0;
    if (rst) begin
      mdu_busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (mdu_go) begin
            mdu_start   = 1'b1;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        // EX holds the MDU op; bubbles drain into MEM so nothing repeats.
        RUN: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
        end
        DONE:    hilo_we = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
